// File: rtl/video_scaler_if.sv
// Renderer / line-buffer bus between video_scaler (master) and the line renderer
// plus double-buffered line RAM (slave).
interface video_scaler_if #(
  parameter int LB_AW = 10
);
  logic             render_start;
  logic [8:0]       render_line;
  logic             linebuf_sel;
  logic [LB_AW-1:0] linebuf_rd_addr;
  logic [7:0]       linebuf_rd_data;

  modport master (
    output render_start, render_line, linebuf_sel, linebuf_rd_addr,
    input  linebuf_rd_data
  );

  modport slave (
    input  render_start, render_line, linebuf_sel, linebuf_rd_addr,
    output linebuf_rd_data
  );
endinterface

// File: rtl/video_scaler.sv
// Active window, border colour and fractional H/V scaling ahead of the VGA timing stage.
// Optional output test pattern (px ^ line) is enabled by defining VIDEO_SCALER_TESTPAT_EN.
module video_scaler #(
  parameter int H_TOTAL = 800,
  parameter int LB_AW   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next_frame,
  input  logic       next_line,
  input  logic       next_pixel,
  input  logic [8:0] display_line_idx,
  input  logic [7:0] hscale,
  input  logic [7:0] vscale,
  input  logic [9:0] hstart,
  input  logic [9:0] hstop,
  input  logic [8:0] vstart,
  input  logic [8:0] vstop,
  input  logic [7:0] border_color,
`ifdef VIDEO_SCALER_TESTPAT_EN
  input  logic       testpat,
`endif
  video_scaler_if.master lb,
  output logic [7:0] palette_idx
);
  localparam logic [9:0] PX_LAST = 10'(H_TOTAL - 1);

  logic [9:0]  px_q, px_d;
  logic [16:0] hacc_q, hacc_d;
  logic        hw;
  logic        hw_p1_q;
  logic [7:0]  border_q;
  logic        nl_p1_q;
  logic [16:0] vacc_q, vacc_d;
  logic        vw;
  logic        blank_pend_q, blank_pend_d;
  logic        line_blank_q, line_blank_d;
  logic        sel_q;
  logic        rs_q, rs_d;
  logic [8:0]  rline_q, rline_d;

  assign hw = (px_q >= hstart) && (px_q < hstop) && !line_blank_q;
  assign vw = (display_line_idx >= vstart) && (display_line_idx < vstop);

  // Stage 0: pixel counter and 10.7 horizontal source accumulator
  always_comb begin
    px_d   = px_q;
    hacc_d = hacc_q;
    if (next_line) begin
      px_d   = '0;
      hacc_d = '0;
    end else if (next_pixel) begin
      px_d = (px_q == PX_LAST) ? '0 : px_q + 10'd1;
      if (hw) hacc_d = hacc_q + {9'd0, hscale};
    end
  end

  // Vertical sequencing runs one cycle after next_line so display_line_idx has settled
  always_comb begin
    vacc_d       = vacc_q;
    rs_d         = 1'b0;
    rline_d      = rline_q;
    blank_pend_d = blank_pend_q;
    line_blank_d = next_line ? blank_pend_q : line_blank_q;
    if (nl_p1_q) begin
      if (vw) begin
        rs_d         = 1'b1;
        rline_d      = vacc_q[15:7];
        vacc_d       = vacc_q + {9'd0, vscale};
        blank_pend_d = 1'b0;
      end else begin
        blank_pend_d = 1'b1;
      end
    end
    if (next_frame) vacc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q         <= '0;
      hacc_q       <= '0;
      hw_p1_q      <= 1'b0;
      border_q     <= '0;
      nl_p1_q      <= 1'b0;
      vacc_q       <= '0;
      blank_pend_q <= 1'b0;
      line_blank_q <= 1'b0;
      sel_q        <= 1'b0;
      rs_q         <= 1'b0;
      rline_q      <= '0;
    end else begin
      px_q         <= px_d;
      hacc_q       <= hacc_d;
      hw_p1_q      <= hw;
      border_q     <= border_color;
      nl_p1_q      <= next_line;
      vacc_q       <= vacc_d;
      blank_pend_q <= blank_pend_d;
      line_blank_q <= line_blank_d;
      sel_q        <= sel_q ^ next_line;
      rs_q         <= rs_d;
      rline_q      <= rline_d;
    end
  end

  assign lb.linebuf_rd_addr = LB_AW'(hacc_q[16:7]);
  assign lb.render_start    = rs_q;
  assign lb.render_line     = rline_q;
  assign lb.linebuf_sel     = sel_q;

  // Stage 1: line RAM data arrives alongside the registered window flag
`ifdef VIDEO_SCALER_TESTPAT_EN
  logic [7:0] px_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) px_p1_q <= '0;
    else        px_p1_q <= px_q[7:0];
  end

  always_comb begin
    if (!hw_p1_q)     palette_idx = border_q;
    else if (testpat) palette_idx = px_p1_q ^ display_line_idx[7:0];
    else              palette_idx = lb.linebuf_rd_data;
  end
`else
  assign palette_idx = hw_p1_q ? lb.linebuf_rd_data : border_q;
`endif
endmodule

// File: tb/tb_video_scaler.sv
// Scoreboard bench for video_scaler: driver pushes per-slot expectations, monitor pops
// one cycle later and on every render_start pulse.
`timescale 1ns/1ps
module tb_video_scaler;
  localparam int H_TOTAL = 800;
  localparam int LB_AW   = 10;
  localparam int M_ONE = 0, M_ZOOM = 1, M_HOLD = 2, M_TPAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       next_frame = 1'b0, next_line = 1'b0, next_pixel = 1'b0;
  logic [8:0] display_line_idx = '0;
  logic [7:0] hscale = 8'd128, vscale = 8'd128;
  logic [9:0] hstart = '0, hstop = 10'd640;
  logic [8:0] vstart = '0, vstop = 9'd511;
  logic [7:0] border_color = 8'h11;
  logic [7:0] palette_idx;
`ifdef VIDEO_SCALER_TESTPAT_EN
  logic       testpat = 1'b0;
`endif

  always #5 clk = ~clk;

  video_scaler_if #(.LB_AW(LB_AW)) lb ();

  video_scaler #(.H_TOTAL(H_TOTAL), .LB_AW(LB_AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_frame       (next_frame),
    .next_line        (next_line),
    .next_pixel       (next_pixel),
    .display_line_idx (display_line_idx),
    .hscale           (hscale),
    .vscale           (vscale),
    .hstart           (hstart),
    .hstop            (hstop),
    .vstart           (vstart),
    .vstop            (vstop),
    .border_color     (border_color),
`ifdef VIDEO_SCALER_TESTPAT_EN
    .testpat          (testpat),
`endif
    .lb               (lb),
    .palette_idx      (palette_idx)
  );

  // Line RAM model: synchronous read, contents = address[7:0]
  always @(posedge clk) lb.linebuf_rd_data <= lb.linebuf_rd_addr[7:0];

  typedef struct { logic [7:0] val; int line; int slot; } pix_t;
  pix_t       pq[$];
  logic [8:0] rq[$];
  int         n_chk = 0, n_pass = 0;
  logic       chk = 1'b0, chk_q = 1'b0;
  bit         prev_vw = 1'b1;
  logic       sel_exp = 1'b0;
  int         vn = 0;

  always @(posedge clk) chk_q <= chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] exp_pix(input int mode, input int s, input int hs, input int he,
                                         input logic [7:0] bord, input bit blank, input logic [8:0] idx);
    int o;
    if (blank || s < hs || s >= he) return bord;
    o = s - hs;
    case (mode)
      M_ZOOM:  o = o >> 1;
      M_HOLD:  o = 0;
      M_TPAT:  o = s ^ int'(idx[7:0]);
      default: ;
    endcase
    return 8'(o);
  endfunction

  task automatic rst_checks(input string tag);
    check({"reset palette_idx ", tag}, 32'(palette_idx), 32'd0);
    check({"reset render_start ", tag}, 32'(lb.render_start), 32'd0);
    check({"reset linebuf_sel ", tag}, 32'(lb.linebuf_sel), 32'd0);
  endtask

  // One full line starting with px==0; next_line (and optionally next_frame) on slot H_TOTAL-1
  task automatic run_line(input int mode, input int hs, input int he, input logic [7:0] hsc,
                          input logic [7:0] bord, input logic [8:0] idx, input bit frame);
    bit         blank, inw, vw, xbad;
    logic [31:0] ea;
    blank = !prev_vw;
    vw    = 1'b0;
    xbad  = 1'b0;
    for (int s = 0; s < H_TOTAL; s++) begin
      @(negedge clk);
      if (s == 0) begin
        check($sformatf("linebuf_sel L%0d", idx), 32'(lb.linebuf_sel), 32'(sel_exp));
        hstart = 10'(hs); hstop = 10'(he); hscale = hsc; border_color = bord;
        display_line_idx = idx;
`ifdef VIDEO_SCALER_TESTPAT_EN
        testpat = (mode == M_TPAT);
`endif
        vw = (idx >= vstart) && (idx < vstop);
        if (vw) begin
          rq.push_back(9'((vn * int'(vscale)) >> 7));
          vn++;
        end
      end
      inw = !blank && s >= hs && s < he;
      if (inw) begin
        ea = (mode == M_ZOOM) ? 32'((s - hs) >> 1) : (mode == M_HOLD) ? 32'd0 : 32'(s - hs);
        check($sformatf("rd_addr L%0d s%0d", idx, s), 32'(lb.linebuf_rd_addr), ea);
      end
      xbad |= $isunknown({palette_idx, lb.render_start, lb.render_line,
                          lb.linebuf_sel, lb.linebuf_rd_addr});
      pq.push_back('{exp_pix(mode, s, hs, he, bord, blank, idx), int'(idx), s});
      chk        = 1'b1;
      next_line  = (s == H_TOTAL - 1);
      next_frame = frame && (s == H_TOTAL - 1);
    end
    check($sformatf("no X outputs L%0d", idx), 32'(xbad), 32'd0);
    prev_vw = vw;
    sel_exp = ~sel_exp;
    if (frame) vn = 0;
  endtask

  initial begin : monitor
    pix_t       e;
    logic [8:0] r;
    forever begin
      @(posedge clk);
      #2;
      if (chk_q && pq.size() > 0) begin
        e = pq.pop_front();
        check($sformatf("palette_idx L%0d s%0d", e.line, e.slot), 32'(palette_idx), 32'(e.val));
      end
      if (lb.render_start !== 1'b0) begin
        if (rq.size() == 0) begin
          check("render_start unexpected", 32'(lb.render_start), 32'd0);
        end else begin
          r = rq.pop_front();
          check("render_line", 32'(lb.render_line), 32'(r));
        end
      end
    end
  end

  initial begin : driver
    #1 rst_n = 1'b0;
    next_pixel = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      next_line = (c == 5);
      #1 rst_checks($sformatf("init c%0d", c));
    end
    @(negedge clk);
    next_line = 1'b0;
    rst_n     = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1 rst_checks("midline assert");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      next_line = (c == 3);
      #1 rst_checks($sformatf("midline c%0d", c));
    end
    @(negedge clk);
    rst_n     = 1'b1;
    next_line = 1'b1;
    sel_exp   = 1'b1;
    prev_vw   = 1'b1;
    vn        = 0;

    run_line(M_ONE,  0,   640, 8'd128, 8'h11, 9'd1, 1'b0);
    run_line(M_ONE,  0,   640, 8'd128, 8'h11, 9'd2, 1'b0);
    run_line(M_ZOOM, 100, 200, 8'd64,  8'h22, 9'd3, 1'b0);
    run_line(M_ONE,  300, 300, 8'd128, 8'h33, 9'd4, 1'b0);
    run_line(M_HOLD, 10,  790, 8'd0,   8'h44, 9'd5, 1'b0);
`ifdef VIDEO_SCALER_TESTPAT_EN
    run_line(M_TPAT, 0,   800, 8'd128, 8'h66, 9'd5, 1'b0);
`endif

    vstart = 9'd10;
    vstop  = 9'd20;
    vscale = 8'd64;
    run_line(M_ONE, 0, 640, 8'd128, 8'h55, 9'd500, 1'b1);
    for (int l = 0; l < 25; l++) run_line(M_ONE, 0, 640, 8'd128, 8'h55, 9'(l), 1'b0);

    @(negedge clk);
    chk        = 1'b0;
    next_line  = 1'b0;
    next_frame = 1'b0;
    repeat (5) @(negedge clk);
    check("pixel scoreboard drained", 32'(pq.size()), 32'd0);
    check("render scoreboard drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/video_scaler.md
Name: video_scaler

Overview:
- Upstream neighbour of the VGA timing/output stage.
- Driven by that stage's next_frame/next_line/next_pixel strobes and display_line_idx.
- Applies the active window, border colour and fractional H/V scaling; requests source lines from the line renderer and reads the double-buffered line buffer.
- Emits an 8-bit palette index one cycle after each pixel slot, so the 1-cycle palette RAM output lines up with the timing stage's 2-cycle active/sync pipeline.

Parameters:
- H_TOTAL, 800, pixel slots per line; pixel counter wraps here.
- LB_AW, 10, line-buffer address width.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- next_frame  in  1  one-cycle pulse, coincident with next_line, one line before visible line 0.
- next_line  in  1  one-cycle pulse on the last pixel slot of each line.
- next_pixel  in  1  pixel-slot enable.
- display_line_idx  in  9  line index being rendered (updates on next_line edge).
- hscale  in  8  horizontal step, 1.7 fixed point (128 = 1:1, 64 = 2x zoom).
- vscale  in  8  vertical step, 1.7 fixed point.
- hstart / hstop  in  10 each  active window columns [hstart, hstop).
- vstart / vstop  in  9 each  active window lines [vstart, vstop).
- border_color  in  8  palette index used outside the window.
- render_start  out  1  pulse requesting the renderer to fill the back line buffer.
- render_line  out  9  source line for render_start.
- linebuf_sel  out  1  buffer currently displayed; renderer writes !linebuf_sel.
- linebuf_rd_addr  out  LB_AW  read address, synchronous RAM, 1-cycle latency.
- linebuf_rd_data  in  8  read data.
- palette_idx  out  8  index for the palette RAM.

Behaviour:
- Reset values: all registers 0, render_start=0, render_line=0, linebuf_sel=0, palette_idx=0 (border pipeline flag cleared).
- Pixel counter px (10 bits):
  - next_line -> px<=0; next_line has priority over next_pixel in the same cycle.
  - Otherwise next_pixel -> px<=px+1.
  - px==H_TOTAL-1 without next_line -> px<=0.
- Horizontal window: hw = (px>=hstart && px<hstop) && !line_blank. hstart>=hstop gives an empty window, so the whole line is border.
- Horizontal accumulator hacc (17 bits: 10 integer . 7 fraction):
  - next_line -> 0.
  - next_pixel && hw -> hacc+hscale, wrapping mod 2^17.
  - linebuf_rd_addr = hacc[16:7], combinational from the register. The first window pixel reads address 0.
  - hscale=0 holds address 0 for the whole line.
- Stage 1: hw_d<=hw, registered.
- Output: palette_idx = hw_d ? linebuf_rd_data : border_reg, where border_reg is border_color registered. This gives 1-cycle latency from pixel slot px to its index.
- Vertical, sequenced by nl_d (next_line delayed 1 cycle):
  - next_frame -> vacc<=0 (17-bit 10.7 accumulator).
  - At nl_d, vw = display_line_idx in [vstart, vstop).
    - vw=1: render_start=1 for exactly one cycle; render_line=vacc[15:7]; vacc<=vacc+vscale; blank_pend<=0.
    - vw=0: no render_start; blank_pend<=1.
  - At each next_line: linebuf_sel toggles and line_blank<=blank_pend. The line requested during line N is therefore displayed during line N+1.
- Reset mid-line: everything returns to reset values. The first valid output follows the next next_line; the first vertical scaling follows the next next_frame.
- render_line integer wraps mod 512; no clamping.

Optional Feature:
- Macro VIDEO_SCALER_TESTPAT_EN.
- Defined: adds input testpat (1 bit). When testpat=1 and hw_d=1, palette_idx = px_d[7:0] ^ display_line_idx[7:0] instead of linebuf_rd_data. linebuf_rd_addr and render_start behave unchanged.
- Undefined: no testpat port; output path exactly as in Behaviour.

Test Plan:
- Reset:
  - Stimulus: rst_n low mid-line with strobes running.
  - Required: palette_idx=0, render_start=0, linebuf_sel=0 while low; after release, next_line then next_pixel x700 produces no X outputs.
- 1:1 window:
  - Stimulus: hscale=128, hstart=0, hstop=640, border_color=0x11, linebuf data = address[7:0].
  - Required: palette_idx = px-1 for px 1..640; 0x11 for px 641..799.
- 2x zoom with border:
  - Stimulus: hscale=64, hstart=100, hstop=200.
  - Required: rd_addr 0,0,1,1,…,49,49 across px 100..199; palette_idx=border outside (1-cycle shifted).
- Vertical window:
  - Stimulus: vscale=64, vstart=10, vstop=20, frame via next_frame.
  - Required: render_start on lines 10..19 only, render_line 0,0,1,1,2,2,3,3,4,4; lines 0..9 and 20+ all border on the following line; linebuf_sel toggles every line.
- Edge cases:
  - Stimulus: hstart=300, hstop=300; hscale=0.
  - Required: all-border line for the empty window; constant rd_addr 0 inside the window for hscale=0.
- Test pattern:
  - Stimulus: VIDEO_SCALER_TESTPAT_EN defined, testpat=1, display_line_idx=5, window full.
  - Required: palette_idx at slot px=12 equals 0x0C^0x05=0x09.
